// File: rtl/pq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pq_pkg                                                               |
// | Shared FSM state encoding and ordering constants for heap_pq_param.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pq_pkg;

    localparam int c_pq_min = 0;
    localparam int c_pq_max = 1;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ENQ_ST    = 4'd1,
        ENQ_RDP   = 4'd2,
        ENQ_SWP   = 4'd3,
        ENQ_SWP2  = 4'd4,
        DEQ_ST    = 4'd5,
        DEQ_ST2   = 4'd6,
        HPFY_ST   = 4'd7,
        HPFY_RDL  = 4'd8,
        HPFY_RDR  = 4'd9,
        HPFY_SWP  = 4'd10,
        HPFY_SWP2 = 4'd11
    } heap_st_t;

endpackage
`default_nettype wire

// File: rtl/mem_swsr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_swsr                                                             |
// | Single-port synchronous RAM, one-cycle registered read.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_swsr #(
    parameter int W  = 32,
    parameter int D  = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] r_mem [D];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        rdata <= r_mem[addr];
    end

endmodule
`default_nettype wire

// File: rtl/heap_pq_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | heap_pq_param                                                        |
// | Parametrised binary-heap priority queue over a single-port RAM.      |
// | Optional statistics enabled by defining HEAP_PQ_STATS_EN.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module heap_pq_param
    import pq_pkg::*;
#(
    parameter int KEY_WIDTH = 16,
    parameter int VAL_WIDTH = 16,
    parameter int LEVELS    = 4,
    parameter int MAX_PQ    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enq,
    input  logic                 deq,
    input  logic                 flush,
    input  logic [KEY_WIDTH-1:0] kvi_key,
    input  logic [VAL_WIDTH-1:0] kvi_val,
    output logic [KEY_WIDTH-1:0] kvo_key,
    output logic [VAL_WIDTH-1:0] kvo_val,
    output logic [LEVELS-1:0]    count,
    output logic                 full,
    output logic                 empty,
    output logic                 busy,
    output logic                 ovf_err,
    output logic                 udf_err,
    output logic [LEVELS-1:0]    hwm
);

    localparam int c_cap = (1 << LEVELS) - 1;
    localparam int c_kvw = KEY_WIDTH + VAL_WIDTH;
    localparam int c_aw  = LEVELS;
    localparam int c_iw  = LEVELS + 1;

    typedef struct packed {
        logic [KEY_WIDTH-1:0] key;
        logic [VAL_WIDTH-1:0] val;
    } kv_t;

    function automatic logic better(input logic [KEY_WIDTH-1:0] a,
                                    input logic [KEY_WIDTH-1:0] b);
        if (MAX_PQ == c_pq_max) return a > b;
        return a < b;
    endfunction

    heap_st_t          r_state, w_state_nxt;
    logic [LEVELS-1:0] r_count, w_count_nxt;
    logic [c_iw-1:0]   r_idx, w_idx_nxt;
    logic [c_iw-1:0]   r_cidx, w_cidx_nxt;
    kv_t               r_cur, w_cur_nxt;
    kv_t               r_child, w_child_nxt;
    kv_t               r_kvo, w_kvo_nxt;
    logic              r_rep, w_rep_nxt;

    logic              w_mem_we;
    logic [c_aw-1:0]   w_mem_addr;
    kv_t               w_mem_wdata;
    logic [c_kvw-1:0]  w_mem_rdata;
    kv_t               w_rd;
    kv_t               w_root;

    logic              w_full, w_empty;
    logic [c_iw-1:0]   w_count_ext, w_left, w_right;

    assign w_rd        = w_mem_rdata;
    assign w_full      = (r_count == LEVELS'(c_cap));
    assign w_empty     = (r_count == '0);
    assign w_count_ext = {1'b0, r_count};
    // r_idx never exceeds the capacity, so its top bit is always zero
    assign w_left      = {r_idx[c_iw-2:0], 1'b0};
    assign w_right     = {r_idx[c_iw-2:0], 1'b1};

    mem_swsr #(
        .W  (c_kvw),
        .D  (c_cap + 1),
        .AW (c_aw)
    ) u_mem (
        .clk   (clk),
        .we    (w_mem_we),
        .addr  (w_mem_addr),
        .wdata (w_mem_wdata),
        .rdata (w_mem_rdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_idx_nxt   = r_idx;
        w_cidx_nxt  = r_cidx;
        w_cur_nxt   = r_cur;
        w_child_nxt = r_child;
        w_rep_nxt   = r_rep;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = r_cur;
        w_root      = r_rep ? r_cur : w_rd;

        case (r_state)
            IDLE: begin
                if (enq && deq && !w_empty) begin
                    w_cur_nxt   = '{key: kvi_key, val: kvi_val};
                    w_rep_nxt   = 1'b1;
                    w_state_nxt = DEQ_ST2;
                end else if (enq && !w_full) begin
                    w_cur_nxt   = '{key: kvi_key, val: kvi_val};
                    w_idx_nxt   = w_count_ext + c_iw'(1);
                    w_state_nxt = ENQ_ST;
                end else if (deq && !w_empty) begin
                    w_rep_nxt   = 1'b0;
                    w_state_nxt = DEQ_ST;
                end
            end
            ENQ_ST: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_idx[c_aw-1:0];
                w_mem_wdata = r_cur;
                w_count_nxt = r_count + LEVELS'(1);
                w_state_nxt = (r_idx == c_iw'(1)) ? IDLE : ENQ_RDP;
            end
            ENQ_RDP: begin
                if (r_idx == c_iw'(1)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_mem_addr  = r_idx[c_aw:1];
                    w_state_nxt = ENQ_SWP;
                end
            end
            ENQ_SWP: begin
                if (better(r_cur.key, w_rd.key)) begin
                    w_mem_we    = 1'b1;
                    w_mem_addr  = r_idx[c_aw-1:0];
                    w_mem_wdata = w_rd;
                    w_idx_nxt   = {1'b0, r_idx[c_aw:1]};
                    w_state_nxt = ENQ_SWP2;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ENQ_SWP2: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_idx[c_aw-1:0];
                w_mem_wdata = r_cur;
                w_state_nxt = ENQ_RDP;
            end
            DEQ_ST: begin
                w_mem_addr  = r_count;
                w_count_nxt = r_count - LEVELS'(1);
                w_state_nxt = DEQ_ST2;
            end
            DEQ_ST2: begin
                // Root is the last leaf for DEQ, or the new entry for REPLACE
                w_mem_we    = 1'b1;
                w_mem_addr  = c_aw'(1);
                w_mem_wdata = w_root;
                w_cur_nxt   = w_root;
                w_idx_nxt   = c_iw'(1);
                w_state_nxt = HPFY_ST;
            end
            HPFY_ST: begin
                if (w_left > w_count_ext) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_mem_addr  = w_left[c_aw-1:0];
                    w_state_nxt = HPFY_RDL;
                end
            end
            HPFY_RDL: begin
                w_child_nxt = w_rd;
                w_cidx_nxt  = w_left;
                if (w_right > w_count_ext) begin
                    w_state_nxt = HPFY_SWP;
                end else begin
                    w_mem_addr  = w_right[c_aw-1:0];
                    w_state_nxt = HPFY_RDR;
                end
            end
            HPFY_RDR: begin
                if (better(w_rd.key, r_child.key)) begin
                    w_child_nxt = w_rd;
                    w_cidx_nxt  = w_right;
                end
                w_state_nxt = HPFY_SWP;
            end
            HPFY_SWP: begin
                if (better(r_child.key, r_cur.key)) begin
                    w_mem_we    = 1'b1;
                    w_mem_addr  = r_idx[c_aw-1:0];
                    w_mem_wdata = r_child;
                    w_state_nxt = HPFY_SWP2;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            HPFY_SWP2: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_cidx[c_aw-1:0];
                w_mem_wdata = r_cur;
                w_idx_nxt   = r_cidx;
                w_state_nxt = HPFY_ST;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_kvo_nxt = r_kvo;
        if (w_mem_we && (w_mem_addr == c_aw'(1))) begin
            w_kvo_nxt = w_mem_wdata;
        end

        if (flush) begin
            w_state_nxt = IDLE;
            w_count_nxt = '0;
            w_kvo_nxt   = '0;
            w_mem_we    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_idx   <= '0;
            r_cidx  <= '0;
            r_cur   <= '0;
            r_child <= '0;
            r_kvo   <= '0;
            r_rep   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_idx   <= w_idx_nxt;
            r_cidx  <= w_cidx_nxt;
            r_cur   <= w_cur_nxt;
            r_child <= w_child_nxt;
            r_kvo   <= w_kvo_nxt;
            r_rep   <= w_rep_nxt;
        end
    end

`ifdef HEAP_PQ_STATS_EN
    logic              r_ovf, r_udf;
    logic [LEVELS-1:0] r_hwm;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
            r_hwm <= '0;
        end else begin
            if ((r_state == IDLE) && !flush && enq && !deq && w_full) begin
                r_ovf <= 1'b1;
            end
            if ((r_state == IDLE) && !flush && deq && !enq && w_empty) begin
                r_udf <= 1'b1;
            end
            if (w_count_nxt > r_hwm) begin
                r_hwm <= w_count_nxt;
            end
        end
    end

    assign ovf_err = r_ovf;
    assign udf_err = r_udf;
    assign hwm     = r_hwm;
`else
    assign ovf_err = 1'b0;
    assign udf_err = 1'b0;
    assign hwm     = '0;
`endif

    assign kvo_key = r_kvo.key;
    assign kvo_val = r_kvo.val;
    assign count   = r_count;
    assign full    = w_full;
    assign empty   = w_empty;
    assign busy    = (r_state != IDLE);

endmodule
`default_nettype wire

// File: doc/heap_pq_param.md
# heap_pq_param

Parametrised heap-based priority queue: successor to the fixed-configuration heap queue. Key width, value width, depth and min/max ordering are module parameters rather than package constants, and ports are flat rather than a `pq_if` modport. It adds three behaviours the earlier queue lacks: an occupancy count output, a single-cycle flush, and optional sticky error/statistics reporting. It sits behind the same host-side enq/deq command logic as the other queues in the study, driven from a single BRAM port.

## Interface
- KEY_WIDTH, 16, priority key bits
- VAL_WIDTH, 16, payload bits
- LEVELS, 4, heap levels; capacity CAP = 2^LEVELS-1 (LEVELS ≥ 1)
- MAX_PQ, 0, 0 = min-queue (smallest key at root), 1 = max-queue
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous reset, active-low (asserted when 0)
- enq  in  1  enqueue request, sampled only when busy=0
- deq  in  1  dequeue request, sampled only when busy=0
- flush  in  1  discard all contents, sampled every cycle
- kvi_key / kvi_val  in  KEY_WIDTH / VAL_WIDTH  entry to insert
- kvo_key / kvo_val  out  KEY_WIDTH / VAL_WIDTH  current root (head) entry
- count  out  LEVELS  number of stored entries
- full / empty  out  1  count==CAP / count==0
- busy  out  1  operation in progress, commands ignored
- ovf_err / udf_err  out  1  sticky errors (only with HEAP_PQ_STATS_EN)
- hwm  out  LEVELS  occupancy high-water mark (only with HEAP_PQ_STATS_EN)

## Operation
- Heap is stored 1-indexed in a single-port RAM of CAP+1 words; word 0 is unused. Children of i are 2i and 2i+1; the parent of i is i>>1. Child index arithmetic is LEVELS+1 bits wide so that it cannot overflow.
- "Better" means key strictly less (MIN) or strictly greater (MAX). Values never participate in comparisons. Equal keys never swap, so FIFO order among equal keys is not guaranteed.
- Command decode in IDLE, in priority order:
  - flush
  - enq&deq&!empty → REPLACE: root ← kvi, then heapify down; count unchanged
  - enq&!full → ENQ
  - deq&!empty → DEQ
  - otherwise no-op
- enq&deq while empty is treated as ENQ.
- ENQ: count+1, write kvi at the new leaf, then sift up. States: ENQ_ST → (ENQ_RDP → ENQ_SWP → ENQ_SWP2)*. Sift-up stops when the node is the root or the parent is not worse than the new entry.
- DEQ: read the last leaf, count−1, write it to the root, then heapify down. States: DEQ_ST → DEQ_ST2 → (HPFY_ST → HPFY_RDL → [HPFY_RDR] → HPFY_SWP → HPFY_SWP2)*.
  - HPFY_RDR is skipped when the right child index is greater than count.
  - Heapify stops when the left child index is greater than count, or when no child is better.
- kvo is a register loaded whenever the RAM is written at address 1.
- kvo is meaningful only while empty=0. After the last entry is dequeued, kvo holds the stale value.
- flush: in any state, on the next edge count←0, state←IDLE and kvo←0. RAM contents are not cleared. flush overrides any command presented in the same cycle.
- Reset mid-operation: same effect as flush, and it also clears the statistics.

## Timing
- Reset values: count=0, empty=1, full=0, busy=0, kvo=0, ovf_err=0, udf_err=0, hwm=0.
- RAM read latency is 1 cycle. The address is driven in state S and the data is used in state S+1.
- Command accepted at edge T (busy=0 in cycle T). busy=1 from T+1 until the cycle the FSM re-enters IDLE. busy is combinational: !(state==IDLE).
- count, full and empty update at the edge after ENQ_ST or DEQ_ST.
- ENQ into an empty queue: 1 busy cycle.
- Each sift-up level costs 3 cycles. Worst-case ENQ is 1+3(LEVELS−1)+1 busy cycles.
- Each heapify level costs at most 5 cycles. DEQ adds 2 cycles of start-up; REPLACE adds 1.
- The new head is visible on kvo the cycle after its root write. It is final when busy falls.

## Configuration
- HEAP_PQ_STATS_EN defined:
  - ovf_err sets on enq&!deq&full in IDLE.
  - udf_err sets on deq&!enq&empty in IDLE.
  - Both clear only on reset.
  - hwm tracks the maximum count since reset; flush does not clear it.
- Undefined: ovf_err, udf_err and hwm are tied to 0 and no statistics registers are built. Queue behaviour is identical either way.

## Structure
- pq_pkg holds the state enum (heap_st_t) and the MIN/MAX encoding constants.
- Key/value structs are built locally from the parameters; comparison is a local function selected by MAX_PQ.
- Sub-module: mem_swsr (single-port synchronous RAM, W=KEY_WIDTH+VAL_WIDTH, D=CAP+1), instantiated once.

## Test plan
- Reset: hold rst=0 for 2 cycles → count=0, empty=1, full=0, busy=0, kvo=0, hwm=0.
- MIN order: enqueue keys 7,3,9,1 → kvo_key after each busy fall is 7,3,3,1; count=4. Then 4 deqs → kvo_key 3,7,9, then empty=1.
- MAX mode (MAX_PQ=1): enqueue 7,3,9,1 → kvo_key 7,7,9,9. Deq → 7.
- Full boundary (LEVELS=4): enqueue 15 keys → full=1. A 16th enq → no busy, count=15, ovf_err=1 (STATS_EN), hwm=15.
- Replace: heap {1,3,7,9}, enq+deq with key 5 → kvo_key=3, count=4. Subsequent deqs yield 5,7,9.
- Flush mid-sift: assert flush during ENQ_SWP → next cycle busy=0, empty=1, kvo=0. Then enq key 4 → kvo_key=4, count=1.
